interrupt_ack_sequencer: RTL and testbench

Sequences the Z80 interrupt-acknowledge response once the interrupt handler has accepted an INT or NMI and the pipeline has flushed. It runs the INTACK bus cycle for maskable interrupts and pushes the return PC onto the stack through the shared memory port. For IM2 it also fetches the vector word. It then issues a single PC redirect to the fetch unit. It sits between the interrupt handler, the memory port arbiter and the fetch/PC unit.

---
 rtl/interrupt_ack_sequencer.sv | 170 +++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_sequencer.sv
// Z80 interrupt-acknowledge sequencer: INTACK cycle, return-PC push, optional IM2 vector
// fetch and a single PC redirect to the fetch unit.
module interrupt_ack_sequencer #(
  parameter logic [15:0] NMI_VECTOR  = 16'h0066,
  parameter logic [15:0] IM1_VECTOR  = 16'h0038,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        intern_INT,
  input  logic        intern_NMI,
  input  logic        im_we,
  input  logic [1:0]  im_wdata,
  input  logic [7:0]  i_reg,
  input  logic [15:0] ret_pc,
  input  logic [15:0] sp_in,
  output logic        inta,
  input  logic [7:0]  ack_data,
  input  logic        ack_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        busy,
  output logic [1:0]  im_mode
);

  typedef enum logic [2:0] {
    StIdle, StAck, StPushH, StPushL, StVecL, StVecH, StRedirect
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, sp_q, vaddr_q, tgt_q, sp_out_q;
  logic [7:0]  vec_q, cnt_q;
  logic [1:0]  mode_q, im_mode_q;
  logic        nmi_q, sp_we_q;
  logic        ack_expired;
  logic        vec_is_rst;
  logic [15:0] target;

  assign ack_expired = (cnt_q == 8'(ACK_TIMEOUT - 1));
  assign vec_is_rst  = (vec_q[7:6] == 2'b11) && (vec_q[2:0] == 3'b111);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Sequence datapath; mode is frozen at the push so the vector decision and target agree.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= '0;
      sp_q      <= '0;
      vaddr_q   <= '0;
      tgt_q     <= '0;
      sp_out_q  <= '0;
      vec_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      im_mode_q <= '0;
      nmi_q     <= 1'b0;
      sp_we_q   <= 1'b0;
    end else begin
      sp_we_q <= 1'b0;
      if (im_we) im_mode_q <= (im_wdata == 2'd3) ? 2'd1 : im_wdata;
      unique case (state_q)
        StIdle: begin
          if (intern_NMI || intern_INT) begin
            pc_q  <= ret_pc;
            sp_q  <= sp_in;
            nmi_q <= intern_NMI;
            cnt_q <= '0;
          end
        end
        StAck: begin
          cnt_q <= cnt_q + 8'd1;
          if (ack_valid)        vec_q <= ack_data;
          else if (ack_expired) vec_q <= 8'hFF;
        end
        StPushL: begin
          if (mem_ack) begin
            sp_we_q  <= 1'b1;
            sp_out_q <= sp_q - 16'd2;
            mode_q   <= im_mode_q;
            vaddr_q  <= {i_reg, vec_q[7:1], 1'b0};
          end
        end
        StVecL: if (mem_ack) tgt_q[7:0] <= mem_rdata;
        StVecH: if (mem_ack) tgt_q[15:8] <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (intern_NMI)      state_d = StPushH;
        else if (intern_INT) state_d = StAck;
      end
      StAck:   if (ack_valid || ack_expired) state_d = StPushH;
      StPushH: if (mem_ack) state_d = StPushL;
      StPushL: begin
        if (mem_ack) state_d = (!nmi_q && im_mode_q == 2'd2) ? StVecL : StRedirect;
      end
      StVecL:     if (mem_ack) state_d = StVecH;
      StVecH:     if (mem_ack) state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    target = IM1_VECTOR;
    if (nmi_q)                target = NMI_VECTOR;
    else if (mode_q == 2'd2)  target = tgt_q;
    else if (mode_q == 2'd0 && vec_is_rst) target = {8'h00, 2'b00, vec_q[5:3], 3'b000};
  end

  always_comb begin
    inta           = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StAck: inta = 1'b1;
      StPushH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd1;
        mem_wdata = pc_q[15:8];
      end
      StPushL: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd2;
        mem_wdata = pc_q[7:0];
      end
      StVecL: begin
        mem_req  = 1'b1;
        mem_addr = vaddr_q;
      end
      StVecH: begin
        mem_req  = 1'b1;
        mem_addr = vaddr_q + 16'd1;
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign sp_we   = sp_we_q;
  assign sp_out  = sp_out_q;
  assign im_mode = im_mode_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: a transaction-level model predicts the bus
// accesses, SP update, INTACK length and redirect target of each interrupt sequence.
module tb_interrupt_ack_sequencer;

  logic        CLK, RST;
  logic        intern_INT, intern_NMI, im_we;
  logic [1:0]  im_wdata;
  logic [7:0]  i_reg;
  logic [15:0] ret_pc, sp_in;
  logic        inta;
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] sp_out;
  logic        sp_we, redirect_valid;
  logic [15:0] redirect_pc;
  logic        busy;
  logic [1:0]  im_mode;

  interrupt_ack_sequencer dut (
    .CLK(CLK), .RST(RST), .intern_INT(intern_INT), .intern_NMI(intern_NMI),
    .im_we(im_we), .im_wdata(im_wdata), .i_reg(i_reg), .ret_pc(ret_pc), .sp_in(sp_in),
    .inta(inta), .ack_data(ack_data), .ack_valid(ack_valid), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .sp_out(sp_out), .sp_we(sp_we), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .im_mode(im_mode)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        mon_a;
  logic [7:0]  mem_model [0:65535];
  logic [15:0] exp_sp, exp_pc, last_pc, last_sp;
  logic [1:0]  exp_mode;
  int          exp_inta, inta_cnt, last_inta;
  int          ack_delay, mem_delay;
  logic        armed, done;
  int          checks, errors;
  logic        prev_req, prev_ack, prev_we;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Device side of INTACK: vector appears on the ack_delay-th INTACK cycle (<0: never).
  initial begin : ack_driver
    int acnt;
    acnt = 0;
    ack_valid = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (inta) begin
        ack_valid = (ack_delay >= 0 && acnt == ack_delay);
        acnt++;
      end else begin
        ack_valid = 1'b0;
        acnt = 0;
      end
    end
  end

  // Memory port: acks after mem_delay stall cycles, reads from mem_model.
  initial begin : mem_responder
    int stall;
    stall = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK); #1;
      if (mem_req && !mem_ack) begin
        if (stall == mem_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_model[mem_addr];
          stall = 0;
        end else begin
          stall++;
        end
      end else begin
        mem_ack = 1'b0;
        if (!mem_req) stall = 0;
      end
    end
  end

  initial begin : monitor
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("im_mode", im_mode, exp_mode);
        if (!busy)
          chk("idle_quiet", {mem_req, mem_we, inta, redirect_valid, mem_addr, mem_wdata}, 0);
        if (inta) inta_cnt++;
        if (mem_req && prev_req && !prev_ack)
          chk("mem_stable", {mem_we, mem_addr, mem_wdata}, {prev_we, prev_addr, prev_wdata});
        if (mem_req && mem_ack) begin
          if (!armed || exp_q.size() == 0) begin
            chk("unexpected_access", {mem_we, mem_addr}, 0);
          end else begin
            mon_a = exp_q.pop_front();
            chk("mem_access", {mem_we, mem_addr, mem_wdata}, mon_a);
          end
        end
        if (sp_we) begin
          if (armed) chk("sp_out", sp_out, exp_sp);
          else       chk("unexpected_sp_we", sp_we, 0);
          last_sp = sp_out;
        end
        if (redirect_valid) begin
          if (armed) begin
            chk("redirect_pc", redirect_pc, exp_pc);
            chk("inta_cycles", inta_cnt, exp_inta);
            chk("accesses_left", exp_q.size(), 0);
            chk("busy_in_redirect", busy, 1);
          end else begin
            chk("unexpected_redirect", redirect_valid, 0);
          end
          last_pc = redirect_pc;
          last_inta = inta_cnt;
          armed = 1'b0;
          done = 1'b1;
        end
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  task automatic set_mode(input logic [1:0] v);
    @(posedge CLK); #1;
    im_we = 1'b1;
    im_wdata = v;
    @(posedge CLK); #1;
    im_we = 1'b0;
    exp_mode = (v == 2'd3) ? 2'd1 : v;
  endtask

  // Builds the expected transaction list for one interrupt and starts it.
  task automatic start(input bit nmi, input bit intr, input logic [15:0] sp,
                       input logic [15:0] pc, input logic [7:0] ireg, input int ackd,
                       input logic [7:0] adata, input int memd);
    logic [7:0]  vec;
    logic [15:0] va, va1;
    bit          got_ack;
    got_ack = (ackd >= 0 && ackd < 8);
    vec = got_ack ? adata : 8'hFF;
    exp_q.delete();
    exp_q.push_back({1'b1, 16'(sp - 16'd1), pc[15:8]});
    exp_q.push_back({1'b1, 16'(sp - 16'd2), pc[7:0]});
    exp_sp = sp - 16'd2;
    if (nmi) begin
      exp_inta = 0;
      exp_pc = 16'h0066;
    end else begin
      exp_inta = got_ack ? ackd + 1 : 8;
      if (exp_mode == 2'd2) begin
        va  = {ireg, vec & 8'hFE};
        va1 = va + 16'd1;
        exp_q.push_back({1'b0, va, 8'h00});
        exp_q.push_back({1'b0, va1, 8'h00});
        exp_pc = {mem_model[va1], mem_model[va]};
      end else if (exp_mode == 2'd0 && (vec & 8'hC7) == 8'hC7) begin
        exp_pc = {8'h00, vec & 8'h38};
      end else begin
        exp_pc = 16'h0038;
      end
    end
    ack_delay = ackd;
    mem_delay = memd;
    ack_data  = adata;
    i_reg     = ireg;
    inta_cnt  = 0;
    done      = 1'b0;
    armed     = 1'b1;
    @(posedge CLK); #1;
    ret_pc = pc;
    sp_in = sp;
    intern_NMI = nmi;
    intern_INT = intr;
    @(posedge CLK); #1;
    intern_NMI = 1'b0;
    intern_INT = 1'b0;
    // Scramble the live inputs so only latched copies can be used.
    ret_pc = ~pc;
    sp_in = ~sp;
  endtask

  task automatic run(input bit nmi, input bit intr, input logic [15:0] sp,
                     input logic [15:0] pc, input logic [7:0] ireg, input int ackd,
                     input logic [7:0] adata, input int memd);
    start(nmi, intr, sp, pc, ireg, ackd, adata, memd);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK); #2;
    end
    if (!done) begin
      chk("redirect_timeout", done, 1);
      armed = 1'b0;
    end
    @(negedge CLK);
    chk("busy_after_redirect", busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    RST = 1'b1; intern_INT = 0; intern_NMI = 0; im_we = 0; im_wdata = 0;
    i_reg = 0; ret_pc = 0; sp_in = 0; ack_data = 0;
    ack_delay = -1; mem_delay = 0; armed = 0; done = 0; exp_mode = 0;
    inta_cnt = 0; last_pc = 0; last_sp = 0; last_inta = 0;
    exp_sp = 0; exp_pc = 0; exp_inta = 0;
    mem_model[16'h3F20] = 8'hCD;
    mem_model[16'h3F21] = 8'hAB;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_state", {mem_req, mem_we, inta, redirect_valid, busy, sp_we, mem_addr,
                        mem_wdata, sp_out, redirect_pc, im_mode}, 0);

    // IM1, vector on third INTACK cycle
    set_mode(2'd1);
    run(0, 1, 16'hDFF0, 16'h1234, 8'h00, 2, 8'h00, 0);
    chk("im1_pc_lit", last_pc, 16'h0038);
    chk("im1_sp_lit", last_sp, 16'hDFEE);
    chk("im1_inta_lit", last_inta, 3);

    // NMI beats a simultaneous INT, even in IM2
    set_mode(2'd2);
    run(1, 1, 16'h8000, 16'h0ABC, 8'h3F, 1, 8'h21, 0);
    chk("nmi_pc_lit", last_pc, 16'h0066);
    chk("nmi_inta_lit", last_inta, 0);

    // IM2 vector fetch with stalls
    run(0, 1, 16'h9000, 16'h4567, 8'h3F, 0, 8'h21, 1);
    chk("im2_pc_lit", last_pc, 16'hABCD);

    // IM0 RST 10h, then IM0 with no device response
    set_mode(2'd0);
    run(0, 1, 16'h7000, 16'h0100, 8'h00, 1, 8'hD7, 0);
    chk("im0_rst_lit", last_pc, 16'h0010);
    run(0, 1, 16'h7000, 16'h0200, 8'h00, -1, 8'h00, 0);
    chk("im0_timeout_pc_lit", last_pc, 16'h0038);
    chk("im0_timeout_inta_lit", last_inta, 8);

    // SP wrap with three stall cycles per access
    run(0, 1, 16'h0000, 16'hBEEF, 8'h00, 0, 8'h00, 3);
    chk("wrap_sp_lit", last_sp, 16'hFFFE);

    // Reset during PUSH_L aborts cleanly
    set_mode(2'd1);
    start(0, 1, 16'h5000, 16'h3333, 8'h00, 0, 8'h00, 3);
    for (int i = 0; i < 100 && !(mem_req && mem_we && mem_addr == 16'h4FFE); i++)
      @(negedge CLK);
    chk("reached_push_l", mem_addr, 16'h4FFE);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    armed = 1'b0;
    exp_q.delete();
    exp_mode = 2'd0;
    @(negedge CLK);
    chk("abort_state", {mem_req, mem_we, inta, redirect_valid, busy, sp_we, mem_addr,
                        mem_wdata, sp_out, redirect_pc, im_mode}, 0);
    repeat (10) @(negedge CLK);

    set_mode(2'd3);
    chk("im3_stored_as_1", im_mode, 2'd1);
    run(0, 1, 16'h1000, 16'h2222, 8'h00, 1, 8'h00, 0);
    chk("post_abort_pc_lit", last_pc, 16'h0038);
    chk("post_abort_sp_lit", last_sp, 16'h0FFE);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
